uart_cmd_parser: RTL and testbench

- Receive-side counterpart to the byte sources that feed uart_tx.
- Consumes bytes from uart_rx and parses ASCII drive commands of the form <letter>[decimal arg] followed by CR/LF.
- Emits one decoded command per line to the motor-control logic.
- Handles malformed lines, inter-byte timeout and receiver framing errors.

---
 rtl/uart_cmd_parser.sv | 196 +++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// ASCII drive-command line parser fed by uart_rx: <letter>[digits] CR/LF -> cmd_code/cmd_arg.
// Optional byte echo path enabled by defining CMD_PARSER_ECHO_EN.
module uart_cmd_parser #(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = CLK_HZ / 10,
    parameter int unsigned MAX_DIGITS     = 3,
    parameter logic [7:0]  DEFAULT_ARG    = 8'd128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_err,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic [7:0] cmd_arg,
    output logic       cmd_err
`ifdef CMD_PARSER_ECHO_EN
    ,
    output logic       echo_valid,
    output logic [7:0] echo_data,
    input  logic       echo_accept,
    output logic       echo_ovf
`endif
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CNT_W = (MAX_DIGITS > 0) ? $clog2(MAX_DIGITS + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_DIGITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARG     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [2:0]       code_reg, code_next;
    logic [7:0]       acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [TMO_W-1:0] tmo_reg, tmo_next;
    logic             cmd_valid_reg, cmd_valid_next;
    logic             cmd_err_reg, cmd_err_next;
    logic [2:0]       cmd_code_reg, cmd_code_next;
    logic [7:0]       cmd_arg_reg, cmd_arg_next;

    // Byte classification
    logic       is_letter;
    logic [2:0] letter_code;
    logic       is_digit;
    logic       is_term;
    logic [11:0] acc_mult;

    always_comb begin
        is_letter   = 1'b0;
        letter_code = 3'd0;
        case (rx_data)
            8'h46, 8'h66: begin is_letter = 1'b1; letter_code = 3'd1; end
            8'h42, 8'h62: begin is_letter = 1'b1; letter_code = 3'd2; end
            8'h4C, 8'h6C: begin is_letter = 1'b1; letter_code = 3'd3; end
            8'h52, 8'h72: begin is_letter = 1'b1; letter_code = 3'd4; end
            8'h53, 8'h73: begin is_letter = 1'b1; letter_code = 3'd5; end
            default: ;
        endcase
    end

    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    // Wide enough that acc*10+9 cannot wrap for any stored acc <= 255
    assign acc_mult = ({4'd0, acc_reg} * 12'd10) + {8'd0, rx_data[3:0]};

    always_comb begin
        state_next     = state_reg;
        code_next      = code_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        tmo_next       = tmo_reg;
        cmd_valid_next = 1'b0;
        cmd_err_next   = 1'b0;
        cmd_code_next  = cmd_code_reg;
        cmd_arg_next   = cmd_arg_reg;

        if (state_reg == IDLE || rx_valid) begin
            tmo_next = '0;
        end else begin
            tmo_next = tmo_reg + 1'b1;
        end

        if (!rx_valid && state_reg != IDLE && tmo_reg == TMO_LAST) begin
            // Line stalled mid-way: abort it, report once
            state_next   = IDLE;
            cmd_err_next = 1'b1;
            tmo_next     = '0;
        end else if (rx_err) begin
            state_next = DISCARD;
        end else if (rx_valid) begin
            case (state_reg)
                IDLE: begin
                    if (is_letter) begin
                        code_next  = letter_code;
                        acc_next   = '0;
                        cnt_next   = '0;
                        state_next = ARG;
                    end else if (!is_term) begin
                        state_next = DISCARD;
                    end
                end
                ARG: begin
                    if (is_digit) begin
                        if (cnt_reg == MAX_CNT || acc_mult > 12'd255) begin
                            state_next = DISCARD;
                        end else begin
                            acc_next = acc_mult[7:0];
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end else if (is_term) begin
                        state_next     = IDLE;
                        cmd_valid_next = 1'b1;
                        cmd_code_next  = code_reg;
                        cmd_arg_next   = (cnt_reg != '0) ? acc_reg : DEFAULT_ARG;
                    end else begin
                        state_next = DISCARD;
                    end
                end
                DISCARD: begin
                    if (is_term) begin
                        state_next   = IDLE;
                        cmd_err_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            code_reg      <= 3'd0;
            acc_reg       <= 8'd0;
            cnt_reg       <= '0;
            tmo_reg       <= '0;
            cmd_valid_reg <= 1'b0;
            cmd_err_reg   <= 1'b0;
            cmd_code_reg  <= 3'd0;
            cmd_arg_reg   <= 8'd0;
        end else begin
            state_reg     <= state_next;
            code_reg      <= code_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            tmo_reg       <= tmo_next;
            cmd_valid_reg <= cmd_valid_next;
            cmd_err_reg   <= cmd_err_next;
            cmd_code_reg  <= cmd_code_next;
            cmd_arg_reg   <= cmd_arg_next;
        end
    end

    assign cmd_valid = cmd_valid_reg;
    assign cmd_err   = cmd_err_reg;
    assign cmd_code  = cmd_code_reg;
    assign cmd_arg   = cmd_arg_reg;

`ifdef CMD_PARSER_ECHO_EN
    logic       echo_valid_reg;
    logic [7:0] echo_data_reg;
    logic       echo_ovf_reg;

    // One-entry echo buffer; a byte arriving into a full, unaccepted buffer is lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_valid_reg <= 1'b0;
            echo_data_reg  <= 8'd0;
            echo_ovf_reg   <= 1'b0;
        end else begin
            if (rx_valid) begin
                if (!echo_valid_reg || echo_accept) begin
                    echo_valid_reg <= 1'b1;
                    echo_data_reg  <= rx_data;
                end else begin
                    echo_ovf_reg <= 1'b1;
                end
            end else if (echo_valid_reg && echo_accept) begin
                echo_valid_reg <= 1'b0;
            end
        end
    end

    assign echo_valid = echo_valid_reg;
    assign echo_data  = echo_data_reg;
    assign echo_ovf   = echo_ovf_reg;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus pushes expected strobes, a negedge monitor pops and compares.
module tb_uart_cmd_parser;

    localparam int T = 100;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic [7:0] cmd_arg;
    logic       cmd_err;
`ifdef CMD_PARSER_ECHO_EN
    logic       echo_valid;
    logic [7:0] echo_data;
    logic       echo_accept;
    logic       echo_ovf;
`endif

    uart_cmd_parser #(
        .CLK_HZ(50_000_000),
        .TIMEOUT_CYCLES(T),
        .MAX_DIGITS(3),
        .DEFAULT_ARG(8'd128)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_err(rx_err),
        .cmd_valid(cmd_valid),
        .cmd_code(cmd_code),
        .cmd_arg(cmd_arg),
        .cmd_err(cmd_err)
`ifdef CMD_PARSER_ECHO_EN
        ,
        .echo_valid(echo_valid),
        .echo_data(echo_data),
        .echo_accept(echo_accept),
        .echo_ovf(echo_ovf)
`endif
    );

    typedef struct {
        bit         is_err;
        logic [2:0] code;
        logic [7:0] arg;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // idx = position of the terminator byte in the line about to be sent
    task automatic push_valid(input logic [2:0] code, input logic [7:0] arg, input int idx);
        exp_t e;
        e.is_err = 1'b0; e.code = code; e.arg = arg; e.cyc = cyc + idx + 1;
        sb.push_back(e);
    endtask

    task automatic push_err(input int idx);
        exp_t e;
        e.is_err = 1'b1; e.code = 3'd0; e.arg = 8'd0; e.cyc = cyc + idx + 1;
        sb.push_back(e);
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rx_valid = 1'b1;
            rx_data  = s[i];
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && (cmd_valid || cmd_err)) begin
            if (cmd_valid && cmd_err) begin
                checks++;
                $display("FAIL both_strobes: cmd_valid=1 cmd_err=1 at cyc %0d, required exclusive", cyc);
            end else if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_strobe: valid=%0b err=%0b code=%0d arg=%0d cyc=%0d, required none",
                         cmd_valid, cmd_err, cmd_code, cmd_arg, cyc);
            end else begin
                exp_t e;
                bit   ok;
                e  = sb.pop_front();
                ok = (cmd_err == e.is_err) && (cyc == e.cyc) &&
                     (e.is_err || (cmd_code == e.code && cmd_arg == e.arg));
                checks++;
                if (ok) begin
                    passes++;
                    $display("strobe %s code=%0d arg=%0d cyc=%0d ok",
                             cmd_err ? "err" : "cmd", cmd_code, cmd_arg, cyc);
                end else begin
                    $display("FAIL strobe: got err=%0b code=%0d arg=%0d cyc=%0d, required err=%0b code=%0d arg=%0d cyc=%0d",
                             cmd_err, cmd_code, cmd_arg, cyc, e.is_err, e.code, e.arg, e.cyc);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_err   = 1'b0;
`ifdef CMD_PARSER_ECHO_EN
        echo_accept = 1'b1;
`endif
        #1;
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_err",   32'(cmd_err),   32'd0);
        check("rst_cmd_code",  32'(cmd_code),  32'd0);
        check("rst_cmd_arg",   32'(cmd_arg),   32'd0);
`ifdef CMD_PARSER_ECHO_EN
        check("rst_echo_valid", 32'(echo_valid), 32'd0);
        check("rst_echo_ovf",   32'(echo_ovf),   32'd0);
`endif
        idle(3);
        rst_n = 1'b1;
        idle(2);

        push_valid(3'd1, 8'd120, 4); send_line("F120\015\012"); idle(3);
        push_valid(3'd5, 8'd128, 1); send_line("s\012");        idle(3);
        send_line("\015\012\015\012");                          idle(3);
        push_err(4);                 send_line("L256\015");     idle(2);
        push_err(5);                 send_line("R0099\015");    idle(2);
        push_err(2);                 send_line("X5\015");
        push_valid(3'd2, 8'd128, 1); send_line("B\015");        idle(2);
        push_valid(3'd4, 8'd255, 4); send_line("r255\015");     idle(2);
        push_valid(3'd1, 8'd0, 4);   send_line("F000\015");     idle(2);

        // Stall mid-line: abort T cycles after the last byte
        push_err(1 + T);             send_line("B4");           idle(T + 5);
        push_valid(3'd1, 8'd7, 2);   send_line("F7\015");       idle(2);

        // Framing error mid-line
        send_line("F1");
        rx_err = 1'b1; idle(1); rx_err = 1'b0;
        push_err(1);                 send_line("0\015");        idle(2);

        // Framing error on the same cycle as a terminator: terminator ignored
        send_line("L");
        rx_valid = 1'b1; rx_data = 8'h0D; rx_err = 1'b1; idle(1);
        rx_valid = 1'b0; rx_err = 1'b0;
        push_err(0);                 send_line("\015");         idle(2);

        // Asynchronous reset mid-line
        send_line("R2");
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("midrst_cmd_err",   32'(cmd_err),   32'd0);
        check("midrst_cmd_code",  32'(cmd_code),  32'd0);
        check("midrst_cmd_arg",   32'(cmd_arg),   32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_line("\015");                                      idle(2);
        push_valid(3'd4, 8'd3, 2);   send_line("R3\015");       idle(3);

`ifdef CMD_PARSER_ECHO_EN
        echo_accept = 1'b0;
        idle(2);
        check("echo_empty", 32'(echo_valid), 32'd0);
        push_err(2);                 send_line("AB\015");
        check("echo_valid_full", 32'(echo_valid), 32'd1);
        check("echo_data_first", 32'(echo_data),  32'h41);
        check("echo_ovf_set",    32'(echo_ovf),   32'd1);
        echo_accept = 1'b1; idle(1); echo_accept = 1'b0;
        check("echo_valid_drop", 32'(echo_valid), 32'd0);
        check("echo_ovf_sticky", 32'(echo_ovf),   32'd1);
        idle(3);
`endif

        idle(5);
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL missing_strobes: %0d outstanding, required 0", sb.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
